// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch definitions: bus widths, reset vector, fetch FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pc_unit_pkg;

    localparam int          ADDR_BUS       = 32;
    localparam int          INST_BUS       = 32;
    localparam logic [31:0] FETCH_RESET_PC = 32'hbfc00000;

    // REQ: request in flight at pc; HOLD: instruction parked while ID stalls;
    // DISCARD: stale request still outstanding after a redirect, data dropped.
    typedef enum logic [1:0] {
        FETCH_REQ     = 2'd0,
        FETCH_HOLD    = 2'd1,
        FETCH_DISCARD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_unit_next_pc_sel.sv
// Next fetch address priority mux: live branch, then pending branch, then pc+4.
// Latency: purely combinational.
// Backpressure: a stalled branch is ignored here; the caller captures it later.
module fetch_pc_unit_next_pc_sel #(
    parameter int ADDR_W = 32
) (
    input  logic              branch_flag_i,
    input  logic              stall_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
    input  logic              pend_valid_i,
    input  logic [ADDR_W-1:0] pend_addr_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic [ADDR_W-1:0] next_pc_o
);

    // Sequential pc+4 wraps naturally at the top of the address space.
    always_comb begin
        next_pc_o = pc_i + ADDR_W'(4);
        if (branch_flag_i && !stall_i) begin
            next_pc_o = branch_addr_i;
        end else if (pend_valid_i) begin
            next_pc_o = pend_addr_i;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// IF stage: owns pc, drives imem req/ack, fills the IF/ID slot {pc, inst}.
// Latency: zero-wait memory gives one instruction per cycle, slot valid 1 cycle after req.
// Backpressure: stall freezes the slot; data arriving under stall is parked (HOLD).
// Optional FETCH_ALIGN_CHECK_EN: misaligned pc skips memory and raises if_adel.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_BUS,
    parameter int                INST_W   = INST_BUS,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic              if_adel,
`endif
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0] if_inst
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] disc_addr_q, disc_addr_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [INST_W-1:0] buf_q, buf_d;
    logic              if_valid_q, if_valid_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic [INST_W-1:0] if_inst_q, if_inst_d;
    logic              adel_q, adel_d;

    logic              misaligned;
    logic              req_live;
    logic              accept;
    logic [ADDR_W-1:0] next_pc;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = (state_q == FETCH_REQ) && (pc_q[1:0] != 2'b00);
    assign if_adel    = adel_q;
`else
    assign misaligned = 1'b0;
`endif

    // A request is on the bus in REQ (unless misaligned) and in DISCARD.
    assign req_live  = (state_q == FETCH_DISCARD) || ((state_q == FETCH_REQ) && !misaligned);
    assign imem_req  = req_live && !rst;
    assign imem_addr = (state_q == FETCH_DISCARD) ? disc_addr_q : pc_q;

    assign accept = !stall && (((state_q == FETCH_REQ) && (imem_ack || misaligned)) ||
                               (state_q == FETCH_HOLD));

    assign if_valid = if_valid_q;
    assign if_pc    = if_pc_q;
    assign if_inst  = if_inst_q;

    fetch_pc_unit_next_pc_sel #(
        .ADDR_W (ADDR_W)
    ) u_next_pc_sel (
        .branch_flag_i (branch_flag),
        .stall_i       (stall),
        .branch_addr_i (branch_addr),
        .pend_valid_i  (pend_valid_q),
        .pend_addr_i   (pend_addr_q),
        .pc_i          (pc_q),
        .next_pc_o     (next_pc)
    );

    // Next-state: flush beats accept, accept beats park/bubble/branch capture.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        disc_addr_d  = disc_addr_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        buf_d        = buf_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_inst_d    = if_inst_q;
        adel_d       = adel_q;

        if (flush) begin
            if_valid_d   = 1'b0;
            pend_valid_d = 1'b0;
            buf_d        = '0;
            adel_d       = 1'b0;
            pc_d         = flush_pc;
            if (req_live && !imem_ack) begin
                // Let the in-flight request finish at its original address.
                state_d     = FETCH_DISCARD;
                disc_addr_d = imem_addr;
            end else begin
                state_d = FETCH_REQ;
            end
        end else if (accept) begin
            if_valid_d   = 1'b1;
            if_pc_d      = pc_q;
            adel_d       = misaligned;
            if (state_q == FETCH_HOLD) begin
                if_inst_d = buf_q;
            end else if (misaligned) begin
                if_inst_d = '0;
            end else begin
                if_inst_d = imem_rdata;
            end
            pc_d         = next_pc;
            pend_valid_d = 1'b0;
            state_d      = FETCH_REQ;
        end else begin
            if ((state_q == FETCH_REQ) && req_live && imem_ack && stall) begin
                buf_d   = imem_rdata;
                state_d = FETCH_HOLD;
            end
            if ((state_q == FETCH_DISCARD) && imem_ack) begin
                state_d = FETCH_REQ;
            end
            if (!stall) begin
                if_valid_d = 1'b0;
                adel_d     = 1'b0;
            end
            // Branch seen while the delay slot is still in flight: remember it.
            if (branch_flag && !stall) begin
                pend_valid_d = 1'b1;
                pend_addr_d  = branch_addr;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH_REQ;
            pc_q         <= RESET_PC;
            disc_addr_q  <= '0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            buf_q        <= '0;
            if_valid_q   <= 1'b0;
            if_pc_q      <= '0;
            if_inst_q    <= '0;
            adel_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            disc_addr_q  <= disc_addr_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            buf_q        <= buf_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_inst_q    <= if_inst_d;
            adel_q       <= adel_d;
        end
    end

endmodule
